gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Parametrised up/down binary counter that presents its count in both binary and Gray code. Both outputs are registered.
- Successor to the combinational 4-bit binary-to-Gray converter: arbitrary width, loadable start value, direction control, wrap indication.
- Intended use: async-FIFO read/write pointers and position encoders. Gray outputs are glitch-free and change exactly one bit per step.

Parameters:
- WIDTH, 4, counter and code width in bits (legal range 2..32).
- RESET_VAL, 0, binary value loaded on reset. gray_out resets to RESET_VAL ^ (RESET_VAL >> 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  synchronous load of load_bin. Overrides en.
- load_bin  input  WIDTH  binary value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- wrap  output  1  registered one-cycle pulse marking a count wrap.

Behaviour:
- Reset:
  - rst_n low immediately forces bin_out=RESET_VAL, gray_out=gray(RESET_VAL), wrap=0, without waiting for a clock edge.
  - Counting resumes on the first rising clk edge after rst_n deasserts.
- Priority each edge: load > en > hold.
- load=1:
  - bin_next=load_bin, gray_next=load_bin ^ (load_bin >> 1), wrap_next=0.
  - up and en are ignored.
- en=1, up=1: bin_next = bin_out + 1 modulo 2^WIDTH.
- en=1, up=0: bin_next = bin_out - 1 modulo 2^WIDTH.
- en=0, load=0: all outputs hold, wrap_next=0.
- Gray encoding:
  - gray_next = bin_next ^ (bin_next >> 1), computed combinationally from bin_next and registered in the same edge as bin_out.
  - Invariant at every edge and after reset: gray_out == bin_out ^ (bin_out >> 1).
  - No extra latency between the two outputs.
- Latency: one clock from en/load sampled to outputs updated.
- wrap:
  - Set to 1 for exactly the cycle following an up-step from all-ones to zero, or a down-step from zero to all-ones.
  - 0 in every other cycle, including after a load that crosses the boundary.
- Step property: on each en step (no load), successive gray_out values differ in exactly one bit, including across wrap.
- Direction change mid-count takes effect on the same edge; no bubble cycle.
- Reset asserted mid-operation aborts any pending load or step. No state survives.
- Width rules: all arithmetic is WIDTH bits, unsigned. Carries and borrows out of the MSB are discarded and used only for wrap detection.

Optional Feature:
- Macro: GRAY_CNT_SATURATE_EN.
- Defined:
  - Counter saturates: up-step at all-ones holds all-ones; down-step at zero holds zero.
  - wrap stays tied to 0.
  - A step blocked by saturation leaves outputs unchanged.
  - Load is unaffected.
- Not defined: modular wrap as described above, with the wrap pulse.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset: hold rst_n=0, then release; also drop rst_n between clock edges mid-count -> bin_out=0000, gray_out=0000, wrap=0 immediately, no clock edge needed.
- Up count: en=1, up=1 for 17 cycles from 0.
  - gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap=1 only in the cycle showing bin_out=0000 after 1111.
  - Checker confirms single-bit change on every step.
- Load: load=1, load_bin=1101, with en=1, up=1 in the same cycle -> next cycle bin_out=1101, gray_out=1011, wrap=0; load wins over en.
- Down wrap and direction change:
  - From 0000 with en=1, up=0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle.
  - Next cycle with up=1 -> bin_out=0000, gray_out=0000, wrap=1.
- Hold: en=0, load=0 for 5 cycles at bin_out=0110 -> outputs stay 0110/0101, wrap=0.
- GRAY_CNT_SATURATE_EN build:
  - Count up from 1110 for 3 cycles -> bin_out 1111,1111,1111, gray_out 1000, wrap always 0.
  - Count down from 0000 -> holds 0000.

Source files
------------

// File: rtl/gray_code_counter.sv
// gray_code_counter
// Parametrised up/down binary counter with registered binary and Gray outputs.
// Gray output is computed from the next binary value and registered on the
// same edge, so both outputs always describe the same count.
//
// Optional build macro: GRAY_CNT_SATURATE_EN
//   defined     -> counter saturates at all-ones / zero, wrap is tied to 0
//   not defined -> modular counting with a one-cycle wrap pulse
module gray_code_counter #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH:0]   STEP     = (WIDTH+1)'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Extended-width increment/decrement; the extra bit is the carry/borrow
    // and only feeds wrap detection.
    always_comb begin
        inc_ext = {1'b0, bin_out} + STEP;
        dec_ext = {1'b0, bin_out} - STEP;
        at_max  = (bin_out == ALL_ONES);
        at_min  = (bin_out == ZERO);
    end

    // Next-state selection: load beats en, en beats hold.
    always_comb begin
        bin_next  = bin_out;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
`ifdef GRAY_CNT_SATURATE_EN
                if (!at_max) begin
                    bin_next = inc_ext[WIDTH-1:0];
                end
`else
                bin_next  = inc_ext[WIDTH-1:0];
                wrap_next = inc_ext[WIDTH];
`endif
            end else begin
`ifdef GRAY_CNT_SATURATE_EN
                if (!at_min) begin
                    bin_next = dec_ext[WIDTH-1:0];
                end
`else
                bin_next  = dec_ext[WIDTH-1:0];
                wrap_next = dec_ext[WIDTH];
`endif
            end
        end
        gray_next = to_gray(bin_next);
    end

`ifdef GRAY_CNT_SATURATE_EN
    // Carry/borrow bits are unused when saturating; fold them away cleanly.
    logic unused_carry;
    always_comb begin
        unused_carry = inc_ext[WIDTH] ^ dec_ext[WIDTH];
    end
`else
    // Boundary flags are only needed for saturation.
    logic unused_flags;
    always_comb begin
        unused_flags = at_max ^ at_min;
    end
`endif

    // Output registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out  <= RESET_VAL;
            gray_out <= RESET_GRAY;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= bin_next;
            gray_out <= gray_next;
            wrap     <= wrap_next;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed, table-driven bench for gray_code_counter (WIDTH=4, RESET_VAL=0).
module tb_gray_code_counter;

`ifdef GRAY_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    gray_code_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [3:0] load_bin;
        logic       en;
        logic       up;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic l, input logic [3:0] lb, input logic e,
                       input logic u, input logic [3:0] b, input logic [3:0] g,
                       input logic w);
        vec_t v;
        v.load = l; v.load_bin = lb; v.en = e; v.up = u;
        v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] b,
                         input logic [3:0] g, input logic w);
        checks++;
        if (bin_out !== b || gray_out !== g || wrap !== w) begin
            errors++;
            $display("FAIL %s: got bin=%b gray=%b wrap=%b, want bin=%b gray=%b wrap=%b",
                     name, bin_out, gray_out, wrap, b, g, w);
        end
    endtask

    task automatic drive(input logic l, input logic [3:0] lb, input logic e,
                         input logic u);
        @(negedge clk);
        load = l; load_bin = lb; en = e; up = u;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev_gray;
    logic [3:0] prev_bin;

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'd0;
        #2;
        check("reset_async", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count through all codes and across the wrap
        add(0, 0, 1, 1, 4'd1,  4'b0001, 0);
        add(0, 0, 1, 1, 4'd2,  4'b0011, 0);
        add(0, 0, 1, 1, 4'd3,  4'b0010, 0);
        add(0, 0, 1, 1, 4'd4,  4'b0110, 0);
        add(0, 0, 1, 1, 4'd5,  4'b0111, 0);
        add(0, 0, 1, 1, 4'd6,  4'b0101, 0);
        add(0, 0, 1, 1, 4'd7,  4'b0100, 0);
        add(0, 0, 1, 1, 4'd8,  4'b1100, 0);
        add(0, 0, 1, 1, 4'd9,  4'b1101, 0);
        add(0, 0, 1, 1, 4'd10, 4'b1111, 0);
        add(0, 0, 1, 1, 4'd11, 4'b1110, 0);
        add(0, 0, 1, 1, 4'd12, 4'b1010, 0);
        add(0, 0, 1, 1, 4'd13, 4'b1011, 0);
        add(0, 0, 1, 1, 4'd14, 4'b1001, 0);
        add(0, 0, 1, 1, 4'd15, 4'b1000, 0);
        add(0, 0, 1, 1, SAT ? 4'd15 : 4'd0, SAT ? 4'b1000 : 4'b0000, SAT ? 1'b0 : 1'b1);
        // Load wins over en
        add(1, 4'd13, 1, 1, 4'd13, 4'b1011, 0);
        // Down wrap then direction change
        add(1, 4'd0, 0, 0, 4'd0, 4'b0000, 0);
        add(0, 0, 1, 0, SAT ? 4'd0 : 4'd15, SAT ? 4'b0000 : 4'b1000, SAT ? 1'b0 : 1'b1);
        add(0, 0, 1, 1, SAT ? 4'd1 : 4'd0,  SAT ? 4'b0001 : 4'b0000, SAT ? 1'b0 : 1'b1);
        // Hold
        add(1, 4'd6, 0, 0, 4'd6, 4'b0101, 0);
        add(0, 0, 0, 0, 4'd6, 4'b0101, 0);
        add(0, 0, 0, 1, 4'd6, 4'b0101, 0);
        add(0, 0, 0, 0, 4'd6, 4'b0101, 0);
        add(0, 0, 0, 1, 4'd6, 4'b0101, 0);
        add(0, 0, 0, 0, 4'd6, 4'b0101, 0);
        // Loads crossing the boundary never pulse wrap
        add(1, 4'd15, 0, 1, 4'd15, 4'b1000, 0);
        add(1, 4'd0,  1, 0, 4'd0,  4'b0000, 0);
        add(0, 0, 1, 0, SAT ? 4'd0 : 4'd15, SAT ? 4'b0000 : 4'b1000, SAT ? 1'b0 : 1'b1);
        add(0, 0, 1, 0, SAT ? 4'd0 : 4'd14, SAT ? 4'b0000 : 4'b1001, 0);
        // Up from 1110 for three cycles
        add(1, 4'd14, 0, 0, 4'd14, 4'b1001, 0);
        add(0, 0, 1, 1, 4'd15, 4'b1000, 0);
        add(0, 0, 1, 1, SAT ? 4'd15 : 4'd0, SAT ? 4'b1000 : 4'b0000, SAT ? 1'b0 : 1'b1);
        add(0, 0, 1, 1, SAT ? 4'd15 : 4'd1, SAT ? 4'b1000 : 4'b0001, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            prev_gray = gray_out;
            prev_bin  = bin_out;
            drive(vecs[i].load, vecs[i].load_bin, vecs[i].en, vecs[i].up);
            check($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_gray,
                  vecs[i].exp_wrap);
            if (!vecs[i].load && vecs[i].en && (bin_out !== prev_bin)) begin
                checks++;
                if ($countones(gray_out ^ prev_gray) != 1) begin
                    errors++;
                    $display("FAIL step_onebit vec%0d: gray %b -> %b", i, prev_gray, gray_out);
                end
            end
        end

        // Mid-count reset between edges, with a wrap pulse and a load pending
        drive(1, 4'd0, 0, 0);
        drive(0, 4'd0, 1, 0);
        check("pre_reset", SAT ? 4'd0 : 4'd15, SAT ? 4'b0000 : 4'b1000, SAT ? 1'b0 : 1'b1);
        load = 1'b1; load_bin = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midcount", 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_step", 4'd1, 4'b0001, 1'b0);
        en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
